// File: rtl/apb3_bridge_pkg.sv
// Shared types and constants for the APB3 slot bridge and its watchdog.
package apb3_bridge_pkg;

    localparam int unsigned SLOT_FIELD_W = 4;
    localparam int unsigned MAX_SLOTS    = 16;
    localparam int unsigned WDOG_W       = 16;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StDone
    } bridge_state_e;

    typedef logic [SLOT_FIELD_W-1:0] slot_idx_t;

    function automatic logic [MAX_SLOTS-1:0] slot_onehot(input slot_idx_t idx);
        return MAX_SLOTS'(1) << idx;
    endfunction

endpackage

// File: rtl/apb3_bridge_wdog.sv
// ACCESS-phase watchdog for the APB3 slot bridge; instantiated only when
// APB3_BRIDGE_TIMEOUT_EN is defined.
module apb3_bridge_wdog
    import apb3_bridge_pkg::*;
#(
    parameter int unsigned Limit = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [WDOG_W-1:0] cnt_q;

    // Expires during the Limit-th enabled cycle, so the caller can still let a
    // same-cycle slave response take priority.
    assign expired_o = en_i && (cnt_q == WDOG_W'(Limit - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + WDOG_W'(1);
        end
    end

endmodule

// File: rtl/apb3_slot_bridge.sv
// Registered APB3 bridge: one master to up to 16 decoded slave slots.
// Optional ACCESS watchdog enabled by defining APB3_BRIDGE_TIMEOUT_EN.
module apb3_slot_bridge
    import apb3_bridge_pkg::*;
#(
    parameter int unsigned NUM_SLOTS   = 3,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned SLOT_LSB    = 12,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                          PCLK,
    input  logic                          PRESETN,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [ADDR_W-1:0]             PADDR,
    input  logic [DATA_W-1:0]             PWDATA,
    output logic [DATA_W-1:0]             PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    output logic [NUM_SLOTS-1:0]          PSELS,
    output logic                          PENABLES,
    output logic                          PWRITES,
    output logic [ADDR_W-1:0]             PADDRS,
    output logic [DATA_W-1:0]             PWDATAS,
    input  logic [NUM_SLOTS*DATA_W-1:0]   PRDATAS,
    input  logic [NUM_SLOTS-1:0]          PREADYS,
    input  logic [NUM_SLOTS-1:0]          PSLVERRS
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = (ADDR_W'(1) << SLOT_LSB) - ADDR_W'(1);

    bridge_state_e                 state_q;
    slot_idx_t                     idx_q;
    slot_idx_t                     req_idx;
    logic                          req_mapped;
    logic [MAX_SLOTS-1:0]          ready_ext;
    logic [MAX_SLOTS-1:0]          err_ext;
    logic [MAX_SLOTS*DATA_W-1:0]   rdata_ext;
    logic [DATA_W-1:0]             slot_rdata;
    logic                          slot_ready;
    logic                          slot_err;
    logic                          wdog_expired;
    logic                          unused_paddr;

    assign req_idx    = PADDR[SLOT_LSB +: SLOT_FIELD_W];
    assign req_mapped = 32'(req_idx) < NUM_SLOTS;

    // Widen the slave buses to the full 16-slot space so the 4-bit index never
    // selects outside the vector.
    assign ready_ext  = MAX_SLOTS'(PREADYS);
    assign err_ext    = MAX_SLOTS'(PSLVERRS);
    assign rdata_ext  = (MAX_SLOTS*DATA_W)'(PRDATAS);
    assign slot_ready = ready_ext[idx_q];
    assign slot_err   = err_ext[idx_q];
    assign slot_rdata = rdata_ext[32'(idx_q)*DATA_W +: DATA_W];

    assign unused_paddr = ^PADDR[ADDR_W-1:SLOT_LSB+SLOT_FIELD_W];

`ifdef APB3_BRIDGE_TIMEOUT_EN
    apb3_bridge_wdog #(
        .Limit     (TIMEOUT_CYC)
    ) u_wdog (
        .clk_i     (PCLK),
        .rst_ni    (PRESETN),
        .clr_i     (state_q == StSetup),
        .en_i      (state_q == StAccess),
        .expired_o (wdog_expired)
    );
`else
    logic unused_timeout_cfg;

    assign wdog_expired       = 1'b0;
    assign unused_timeout_cfg = ^WDOG_W'(TIMEOUT_CYC);
`endif

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            PRDATA   <= '0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            PSELS    <= '0;
            PENABLES <= 1'b0;
            PWRITES  <= 1'b0;
            PADDRS   <= '0;
            PWDATAS  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (PSEL && !PENABLE) begin
                        idx_q   <= req_idx;
                        PADDRS  <= PADDR & ADDR_MASK;
                        PWDATAS <= PWDATA;
                        PWRITES <= PWRITE;
                        if (req_mapped) begin
                            PSELS   <= NUM_SLOTS'(slot_onehot(req_idx));
                            state_q <= StSetup;
                        end else begin
                            // Unmapped slot: answer the master directly with an error.
                            PRDATA  <= '0;
                            PREADY  <= 1'b1;
                            PSLVERR <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StSetup: begin
                    PENABLES <= 1'b1;
                    state_q  <= StAccess;
                end
                StAccess: begin
                    if (slot_ready) begin
                        PRDATA   <= PWRITES ? '0 : slot_rdata;
                        PSLVERR  <= slot_err;
                        PREADY   <= 1'b1;
                        PSELS    <= '0;
                        PENABLES <= 1'b0;
                        state_q  <= StDone;
                    end else if (wdog_expired) begin
                        PRDATA   <= '0;
                        PSLVERR  <= 1'b1;
                        PREADY   <= 1'b1;
                        PSELS    <= '0;
                        PENABLES <= 1'b0;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb3_slot_bridge.sv
// Self-checking bench for apb3_slot_bridge: directed cases plus randomized transfers
// checked against a transfer-level model; covers APB3_BRIDGE_TIMEOUT_EN either way.
module tb_apb3_slot_bridge;

    localparam int unsigned NS  = 3;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned TMO = 16;
`ifdef APB3_BRIDGE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic              PCLK = 1'b0;
    logic              PRESETN = 1'b1;
    logic              PSEL, PENABLE, PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [DW-1:0]     PRDATA;
    logic              PREADY, PSLVERR;
    logic [NS-1:0]     PSELS;
    logic              PENABLES, PWRITES;
    logic [AW-1:0]     PADDRS;
    logic [DW-1:0]     PWDATAS;
    logic [NS*DW-1:0]  PRDATAS;
    logic [NS-1:0]     PREADYS, PSLVERRS;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave model: every slot inserts wait_cfg wait states, then returns its data word.
    int            wait_cfg = 0;
    int            acc_cnt;
    logic [DW-1:0] slot_data [NS];
    logic [NS-1:0] err_cfg = '0;

    always #5 PCLK = ~PCLK;

    apb3_slot_bridge #(
        .NUM_SLOTS   (NS),
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .SLOT_LSB    (12),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .PCLK     (PCLK),
        .PRESETN  (PRESETN),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .PSELS    (PSELS),
        .PENABLES (PENABLES),
        .PWRITES  (PWRITES),
        .PADDRS   (PADDRS),
        .PWDATAS  (PWDATAS),
        .PRDATAS  (PRDATAS),
        .PREADYS  (PREADYS),
        .PSLVERRS (PSLVERRS)
    );

    always @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) acc_cnt <= 0;
        else          acc_cnt <= PENABLES ? acc_cnt + 1 : 0;
    end

    assign PREADYS  = (PENABLES && acc_cnt >= wait_cfg) ? PSELS : '0;
    assign PSLVERRS = err_cfg;
    assign PRDATAS  = {slot_data[2], slot_data[1], slot_data[0]};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Master-side transfer; cycles counts the setup cycle plus every access cycle.
    task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                        input int budget, output int cycles, output logic [DW-1:0] rd,
                        output logic err, output logic [NS-1:0] seen);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wd;
        cycles  = 1;
        seen    = '0;
        do begin
            @(posedge PCLK); #1;
            PENABLE = 1'b1;
            cycles++;
            seen |= PSELS;
        end while (!PREADY && cycles < budget);
        rd  = PRDATA;
        err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    // Transfer-level model: outcome follows from slot mapping, wait count and timeout rule.
    task automatic run_one(input string tag, input logic [AW-1:0] addr, input logic wr,
                           input logic [DW-1:0] wd, input int waits);
        int            slot, exp_cyc, cyc;
        bit            mapped, tmo;
        logic [DW-1:0] exp_rd, rd;
        logic          exp_err, err;
        logic [NS-1:0] exp_sel, seen;
        slot     = int'(addr[15:12]);
        mapped   = slot < NS;
        tmo      = mapped && TMO_EN && (waits + 1 > TMO);
        wait_cfg = waits;
        if (!mapped)  exp_cyc = 2;
        else if (tmo) exp_cyc = 3 + TMO;
        else          exp_cyc = 4 + waits;
        exp_rd  = (!mapped || tmo || wr) ? '0 : slot_data[slot];
        exp_err = (!mapped || tmo) ? 1'b1 : err_cfg[slot];
        exp_sel = mapped ? NS'(1 << slot) : '0;
        xfer(addr, wr, wd, 200, cyc, rd, err, seen);
        check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_prdata"}, 64'(rd), 64'(exp_rd));
        check({tag, "_pslverr"}, 64'(err), 64'(exp_err));
        check({tag, "_psels"}, 64'(seen), 64'(exp_sel));
        check({tag, "_paddrs"}, 64'(PADDRS), 64'(addr & 32'h0000_0FFF));
        check({tag, "_pwdatas"}, 64'(PWDATAS), 64'(wd));
        check({tag, "_pwrites"}, 64'(PWRITES), 64'(wr));
        check({tag, "_pulse"}, 64'({PREADY, PSLVERR}), 64'(0));
    endtask

    initial begin
        bit got;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        for (int k = 0; k < NS; k++) slot_data[k] = $urandom;
        #2 PRESETN = 1'b0;
        #10;
        check("reset_ctl", 64'({PRDATA, PREADY, PSLVERR, PSELS, PENABLES, PWRITES}), 64'(0));
        check("reset_dat", {PADDRS, PWDATAS}, 64'(0));
        @(posedge PCLK); #1 PRESETN = 1'b1;
        @(posedge PCLK); #1;

        run_one("wr_slot0", 32'h0000_0010, 1'b1, 32'hA5A5_0001, 0);
        slot_data[2] = 32'hDEAD_BEEF;
        run_one("rd_slot2_w3", 32'h0000_2004, 1'b0, 32'h0, 3);
        run_one("unmapped5", 32'h0000_5000, 1'b0, 32'h0, 0);
        err_cfg = 3'b010;
        run_one("slverr1", 32'h0000_1000, 1'b0, 32'h0, 0);
        err_cfg = 3'b000;
        run_one("after_err", 32'h0000_1008, 1'b0, 32'h0, 1);

        for (int i = 0; i < 30; i++) begin
            logic [AW-1:0] a;
            int            s;
            s       = $urandom_range(0, 5);
            a       = {16'($urandom), 4'(s), 12'($urandom)};
            err_cfg = NS'($urandom);
            for (int k = 0; k < NS; k++) slot_data[k] = $urandom;
            run_one($sformatf("rnd%0d", i), a, 1'($urandom), $urandom, $urandom_range(0, 4));
        end
        err_cfg = '0;

        // Master abandons the transfer after one access cycle; slave side must still finish.
        wait_cfg = 2;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 32'h0000_0100; PWDATA = 32'h1234_5678;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge PCLK); #1;
            if (PREADY) got = 1'b1;
        end
        check("drop_done", 64'(got), 64'(1));
        check("drop_idle", 64'({PSELS, PENABLES, PREADY}), 64'(0));
        run_one("after_drop", 32'h0000_2010, 1'b0, 32'h0, 0);

        // Reset asserted while a slot-1 read waits in ACCESS.
        wait_cfg = 1000;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0000_1020;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        check("rst_pre", 64'({PSELS, PENABLES}), 64'(4'b0101));
        PRESETN = 1'b0;
        #1;
        check("rst_ctl", 64'({PRDATA, PREADY, PSLVERR, PSELS, PENABLES, PWRITES}), 64'(0));
        check("rst_dat", {PADDRS, PWDATAS}, 64'(0));
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1 PRESETN = 1'b1;
        @(posedge PCLK); #1;
        run_one("post_rst", 32'h0000_1004, 1'b0, 32'h0, 0);

`ifdef APB3_BRIDGE_TIMEOUT_EN
        run_one("tmo_edge", 32'h0000_0044, 1'b0, 32'h0, TMO - 1);
        run_one("tmo", 32'h0000_0040, 1'b0, 32'h0, 1000000);
        run_one("after_tmo", 32'h0000_0048, 1'b1, 32'h55AA_55AA, 0);
`else
        // Without the watchdog a never-ready slave keeps the bridge in ACCESS.
        wait_cfg = 1000000;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0000_0040;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge PCLK); #1;
            if (PREADY) got = 1'b1;
        end
        check("hang_noready", 64'(got), 64'(0));
        check("hang_access", 64'({PSELS, PENABLES}), 64'(4'b0011));
        PSEL = 1'b0; PENABLE = 1'b0;
        PRESETN = 1'b0;
        @(posedge PCLK); #1 PRESETN = 1'b1;
        @(posedge PCLK); #1;
        run_one("after_hang", 32'h0000_0048, 1'b1, 32'h55AA_55AA, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "global timeout");
    end

endmodule
